rst_sequencer: RTL and testbench
================================

# rst_sequencer

Reset sequencer for the LVDS transceiver. It holds a chain of per-domain resets asserted until the PLL reports lock. It then releases them one stage at a time, in fixed order (e.g. SERDES, then aligner/bitslip, then link layer), waiting for each stage's done flag before releasing the next. It sits between the clocking block and the per-domain reset synchronizers, retries on stage timeout, and latches a fault after too many failed attempts.

## Interface

Parameters:
- NUM_STAGES, 3: number of sequenced reset outputs (1..8).
- HOLD_CYCLES, 16: cycles all resets stay asserted after lock before stage 0 is released (≥1).
- TIMEOUT_CYCLES, 1024: maximum wait for a stage's done flag after its release (≥2).
- MAX_RETRY, 3: retries allowed before fault (0..15).

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_pll_locked  in  1  PLL lock; already synchronous to i_clk.
- i_soft_rst  in  1  single-cycle request to rerun the whole sequence.
- i_stage_done  in  NUM_STAGES  per-stage ready/done flags, synchronous to i_clk.
- o_rst  out  NUM_STAGES  per-stage reset, active-high, registered.
- o_ready  out  1  all stages released and done (state RUN).
- o_busy  out  1  sequence in progress (any state other than RUN or FAULT).
- o_fault  out  1  retry budget exhausted (state FAULT).
- o_retry_cnt  out  4  number of timeouts in the current sequence attempt.

## Operation

- Reset (i_rst=1 at an edge): o_rst all ones, o_ready=0, o_busy=1, o_fault=0, o_retry_cnt=0, stage index k=0, counters 0, state WAIT_LOCK.
- WAIT_LOCK: all o_rst=1. If i_pll_locked=1, go to HOLD with the counter cleared.
- HOLD: all o_rst=1. The counter increments each cycle. When counter==HOLD_CYCLES-1, set k=0 and go to RELEASE.
- RELEASE: o_rst[k]<=0 and lower stages stay 0. Clear the timer and go to WAIT_DONE.
- WAIT_DONE: sample i_stage_done[k] only; flags of stages above k are ignored.
  - done=1 and k==NUM_STAGES-1: go to RUN.
  - done=1 otherwise: k<=k+1, go to RELEASE.
  - done=0 and timer==TIMEOUT_CYCLES-1: timeout.
  - otherwise: timer++.
- Timeout:
  - If o_retry_cnt<MAX_RETRY: o_retry_cnt++, all o_rst<=1, counter cleared, go to HOLD.
  - Else: go to FAULT. o_rst stays as is, so released stages remain released for debug.
- RUN: o_ready=1; all o_rst=0. Deassertion of i_stage_done in RUN is ignored.
- FAULT: o_fault=1. Exits only on i_rst or i_soft_rst.
- Lock loss (i_pll_locked=0) in any state except WAIT_LOCK and FAULT: all o_rst<=1, o_ready<=0, go to WAIT_LOCK. o_retry_cnt is unchanged.
- i_soft_rst=1 in any state:
  - all o_rst<=1, o_ready<=0, o_fault<=0, o_retry_cnt<=0.
  - Go to HOLD if i_pll_locked=1, else WAIT_LOCK.
- Priority within one cycle: i_rst > lock loss > i_soft_rst > done > timeout.
- Widths:
  - HOLD counter: $clog2(HOLD_CYCLES) bits, minimum 1.
  - Timer: $clog2(TIMEOUT_CYCLES) bits.
  - k: $clog2(NUM_STAGES) bits, minimum 1.
- No counter ever wraps; each counter is cleared on state entry.

## Timing

- All outputs are registered and change only on the i_clk edge of the state transition that sets them.
- Lock sampled high at edge t:
  - HOLD spans edges t+1..t+HOLD_CYCLES.
  - o_rst[0] falls at edge t+HOLD_CYCLES+1.
- i_stage_done[k] sampled high at edge e (k<NUM_STAGES-1): o_rst[k+1] falls at edge e+1. Minimum spacing between releases is 2 cycles.
- Last stage done sampled at edge e: o_ready=1 and o_busy=0 from edge e.
- Timeout: the timeout decision is taken on the TIMEOUT_CYCLES-th WAIT_DONE edge. All o_rst reassert on that same edge.
- Lock loss, soft reset or i_rst sampled at edge e: all o_rst=1 from edge e. There is no partial release.
- i_rst mid-sequence behaves identically to power-on reset.

## Test plan

- Nominal sequence: NUM_STAGES=3, HOLD_CYCLES=16; lock rises, each done asserted 5 cycles after its o_rst falls.
  - o_rst[0] falls 17 cycles after the lock edge.
  - o_rst[1] and o_rst[2] each fall 1 cycle after the previous done.
  - o_ready=1 on the edge stage 2 done is sampled; o_retry_cnt=0.
- Timeout and retry: TIMEOUT_CYCLES=32, stage 1 never done.
  - All o_rst reassert 32 cycles after o_rst[1] falls; o_retry_cnt steps 1,2,3.
  - Fourth timeout gives o_fault=1 with o_rst=3'b100.
  - i_soft_rst then clears o_fault and o_retry_cnt, and the sequence restarts.
- Lock loss mid-sequence: drop i_pll_locked while in WAIT_DONE for stage 1.
  - Next edge: o_rst=3'b111, o_busy=1, o_retry_cnt unchanged.
  - Relock: full sequence repeats from HOLD.
- Simultaneous events:
  - Done and timeout on the same edge: release proceeds.
  - i_soft_rst and lock loss together: state WAIT_LOCK with o_retry_cnt=0.
- i_rst in RUN: next edge o_rst all ones, o_ready=0, state WAIT_LOCK. Release HOLD_CYCLES+1 cycles after lock is sampled.

Source files
------------

// File: rtl/rst_sequencer.sv
// rst_sequencer
//
// Reset sequencer for the LVDS transceiver. After the PLL reports lock, all
// per-domain resets are held for HOLD_CYCLES. The resets are then released one
// stage at a time in fixed index order (stage 0 first). The sequencer waits for
// each stage's done flag before releasing the next one. If a stage does not
// report done within TIMEOUT_CYCLES, the whole chain is reasserted and the
// sequence is retried. Once MAX_RETRY retries are used up, the sequencer
// latches FAULT and leaves the released stages untouched so they can be debugged.
//
// Ports
//   i_clk         system clock (single domain)
//   i_rst         synchronous active-high reset
//   i_pll_locked  PLL lock, already synchronous to i_clk
//   i_soft_rst    single-cycle request to rerun the whole sequence
//   i_stage_done  per-stage done flags (only the stage being waited on is used)
//   o_rst         per-stage resets, active-high, registered
//   o_ready       all stages released and done (RUN)
//   o_busy        sequence in progress (not RUN and not FAULT)
//   o_fault       retry budget exhausted (FAULT)
//   o_retry_cnt   timeouts seen in the current sequence attempt

module rst_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pll_locked,
  input  logic                  i_soft_rst,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  output logic [NUM_STAGES-1:0] o_rst,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_fault,
  output logic [3:0]            o_retry_cnt
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NUM_STAGES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_RELEASE,
    S_WAIT_DONE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [KW-1:0]         k_q, k_d;
  logic [3:0]            retry_d;
  logic [NUM_STAGES-1:0] rst_d;
  logic                  ready_d;
  logic                  busy_d;
  logic                  fault_d;
  logic                  lock_lost;

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_WAIT_LOCK;
      hold_cnt_q  <= '0;
      timer_q     <= '0;
      k_q         <= '0;
      o_retry_cnt <= '0;
      o_rst       <= '1;
      o_ready     <= 1'b0;
      o_busy      <= 1'b1;
      o_fault     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      timer_q     <= timer_d;
      k_q         <= k_d;
      o_retry_cnt <= retry_d;
      o_rst       <= rst_d;
      o_ready     <= ready_d;
      o_busy      <= busy_d;
      o_fault     <= fault_d;
    end
  end

  // Lock loss is ignored while already waiting for lock, and it is also
  // ignored in FAULT, where the fault stays latched until a reset.
  assign lock_lost = !i_pll_locked && (state_q != S_WAIT_LOCK) && (state_q != S_FAULT);

  // Next-state, counter and retry bookkeeping
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    timer_d    = timer_q;
    k_d        = k_q;
    retry_d    = o_retry_cnt;

    if (lock_lost) begin
      state_d = S_WAIT_LOCK;
      // A soft reset arriving together with lock loss still clears the
      // retry budget. Only its choice of target state is overridden.
      if (i_soft_rst) begin
        retry_d = '0;
      end
    end else if (i_soft_rst) begin
      retry_d    = '0;
      hold_cnt_d = '0;
      state_d    = i_pll_locked ? S_HOLD : S_WAIT_LOCK;
    end else begin
      unique case (state_q)
        S_WAIT_LOCK: begin
          if (i_pll_locked) begin
            hold_cnt_d = '0;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            k_d     = '0;
            state_d = S_RELEASE;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
        S_RELEASE: begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // A done flag wins over a timeout that expires on the same edge.
          if (i_stage_done[k_q]) begin
            if (k_q == K_LAST) begin
              state_d = S_RUN;
            end else begin
              k_d     = k_q + KW'(1);
              state_d = S_RELEASE;
            end
          end else if (timer_q == TMO_LAST) begin
            if (o_retry_cnt < RETRY_MAX) begin
              retry_d    = o_retry_cnt + 4'd1;
              hold_cnt_d = '0;
              state_d    = S_HOLD;
            end else begin
              state_d = S_FAULT;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_RUN:   state_d = S_RUN;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_WAIT_LOCK;
      endcase
    end
  end

  // Registered-output next values. These are derived from the state being
  // entered, so every output changes on the same edge as its transition.
  always_comb begin
    rst_d   = o_rst;
    ready_d = (state_d == S_RUN);
    busy_d  = (state_d != S_RUN) && (state_d != S_FAULT);
    fault_d = (state_d == S_FAULT);

    unique case (state_d)
      S_WAIT_LOCK, S_HOLD: rst_d = '1;
      S_RUN:               rst_d = '0;
      S_FAULT:             rst_d = o_rst;
      default: begin
        // Leaving RELEASE frees stage k and keeps every lower stage free.
        if ((state_q == S_RELEASE) && (state_d == S_WAIT_DONE)) begin
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            rst_d[i] = (i > 32'(k_q));
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer
//
// Directed testbench for rst_sequencer with NUM_STAGES=3, HOLD_CYCLES=16,
// TIMEOUT_CYCLES=32 and MAX_RETRY=3. Inputs are driven 1 ns after each rising
// edge. Outputs are sampled at that same point, so every value checked
// reflects the edge that has just passed.

module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic [2:0] stage_done = 3'b000;
  logic [2:0] rst_out;
  logic       ready;
  logic       busy;
  logic       fault;
  logic [3:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .NUM_STAGES     (3),
    .HOLD_CYCLES    (16),
    .TIMEOUT_CYCLES (32),
    .MAX_RETRY      (3)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pll_locked (pll_locked),
    .i_soft_rst   (soft_rst),
    .i_stage_done (stage_done),
    .o_rst        (rst_out),
    .o_ready      (ready),
    .o_busy       (busy),
    .o_fault      (fault),
    .o_retry_cnt  (retry_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Power-on reset
    ticks(2);
    check("reset_rst",   32'(rst_out),   32'h7);
    check("reset_ready", 32'(ready),     32'h0);
    check("reset_busy",  32'(busy),      32'h1);
    check("reset_fault", 32'(fault),     32'h0);
    check("reset_retry", 32'(retry_cnt), 32'h0);
    rst = 1'b0;
    ticks(3);
    check("wait_lock_rst", 32'(rst_out), 32'h7);

    // Nominal sequence: lock sampled at edge t, stage 0 released at t+17
    pll_locked = 1'b1;
    ticks(1);
    ticks(16);
    check("nom_hold_end", 32'(rst_out), 32'h7);
    ticks(1);
    check("nom_rel0", 32'(rst_out), 32'h6);
    ticks(4);
    stage_done[0] = 1'b1;
    ticks(1);
    check("nom_done0_edge", 32'(rst_out), 32'h6);
    ticks(1);
    check("nom_rel1", 32'(rst_out), 32'h4);
    ticks(4);
    stage_done[1] = 1'b1;
    ticks(1);
    check("nom_done1_edge", 32'(rst_out), 32'h4);
    ticks(1);
    check("nom_rel2", 32'(rst_out), 32'h0);
    ticks(4);
    check("nom_not_ready", 32'(ready), 32'h0);
    stage_done[2] = 1'b1;
    ticks(1);
    check("nom_ready", 32'(ready),     32'h1);
    check("nom_busy",  32'(busy),      32'h0);
    check("nom_retry", 32'(retry_cnt), 32'h0);
    check("nom_rst",   32'(rst_out),   32'h0);

    // Done flags dropping in RUN are ignored
    stage_done = 3'b000;
    ticks(2);
    check("run_ignore_done", 32'(ready), 32'h1);

    // i_rst while in RUN
    rst = 1'b1;
    ticks(1);
    check("rstrun_rst",   32'(rst_out), 32'h7);
    check("rstrun_ready", 32'(ready),   32'h0);
    check("rstrun_busy",  32'(busy),    32'h1);
    rst = 1'b0;
    ticks(1);
    ticks(16);
    check("rstrun_hold_end", 32'(rst_out), 32'h7);
    ticks(1);
    check("rstrun_rel0", 32'(rst_out), 32'h6);

    // Timeout and retry: stage 1 never reports done
    stage_done[0] = 1'b1;
    ticks(2);
    check("tmo_rel1", 32'(rst_out), 32'h4);
    for (int a = 1; a <= 4; a++) begin
      ticks(31);
      check("tmo_pre", 32'(rst_out), 32'h4);
      ticks(1);
      if (a <= 3) begin
        check("tmo_reassert", 32'(rst_out),   32'h7);
        check("tmo_retry",    32'(retry_cnt), 32'(a));
        ticks(17);
        check("tmo_rerel0", 32'(rst_out), 32'h6);
        ticks(2);
        check("tmo_rerel1", 32'(rst_out), 32'h4);
      end else begin
        check("fault_flag",  32'(fault),     32'h1);
        check("fault_rst",   32'(rst_out),   32'h4);
        check("fault_retry", 32'(retry_cnt), 32'h3);
        check("fault_busy",  32'(busy),      32'h0);
        check("fault_ready", 32'(ready),     32'h0);
      end
    end
    ticks(5);
    check("fault_latched", 32'(fault), 32'h1);

    // Soft reset out of FAULT, with lock still present
    soft_rst = 1'b1;
    ticks(1);
    soft_rst = 1'b0;
    check("soft_fault",  32'(fault),     32'h0);
    check("soft_retry",  32'(retry_cnt), 32'h0);
    check("soft_rst",    32'(rst_out),   32'h7);
    check("soft_busy",   32'(busy),      32'h1);
    ticks(16);
    check("soft_hold_end", 32'(rst_out), 32'h7);
    ticks(1);
    check("soft_rel0", 32'(rst_out), 32'h6);
    ticks(2);
    check("soft_rel1", 32'(rst_out), 32'h4);
    ticks(32);
    check("soft_tmo_retry", 32'(retry_cnt), 32'h1);
    ticks(19);
    check("soft_rerel1", 32'(rst_out), 32'h4);

    // Lock loss in WAIT_DONE for stage 1
    ticks(3);
    pll_locked = 1'b0;
    ticks(1);
    check("ll_rst",   32'(rst_out),   32'h7);
    check("ll_busy",  32'(busy),      32'h1);
    check("ll_ready", 32'(ready),     32'h0);
    check("ll_retry", 32'(retry_cnt), 32'h1);
    ticks(3);
    check("ll_wait", 32'(rst_out), 32'h7);
    pll_locked = 1'b1;
    ticks(1);
    ticks(16);
    check("relock_hold_end", 32'(rst_out), 32'h7);
    ticks(1);
    check("relock_rel0",  32'(rst_out),   32'h6);
    check("relock_retry", 32'(retry_cnt), 32'h1);
    ticks(2);
    check("relock_rel1", 32'(rst_out), 32'h4);

    // Done and timeout on the same edge: the release proceeds
    ticks(31);
    stage_done[1] = 1'b1;
    ticks(1);
    check("both_rst",   32'(rst_out),   32'h4);
    check("both_retry", 32'(retry_cnt), 32'h1);
    ticks(1);
    check("both_rel2", 32'(rst_out), 32'h0);

    // Soft reset together with lock loss
    pll_locked = 1'b0;
    soft_rst   = 1'b1;
    ticks(1);
    soft_rst = 1'b0;
    check("sll_rst",   32'(rst_out),   32'h7);
    check("sll_retry", 32'(retry_cnt), 32'h0);
    check("sll_busy",  32'(busy),      32'h1);
    check("sll_fault", 32'(fault),     32'h0);
    ticks(2);
    check("sll_wait", 32'(rst_out), 32'h7);
    pll_locked = 1'b1;
    ticks(1);
    ticks(16);
    check("sll_hold_end", 32'(rst_out), 32'h7);
    ticks(1);
    check("sll_rel0", 32'(rst_out), 32'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
